// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall and taken-branch squash control
// for the PC, IF/ID and ID/EX buffers, with saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter logic [3:0] LOAD_OP      = 4'b1110,
  parameter int         STALL_CYCLES = 1,
  parameter int         FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  id_opcode,
  input  logic [5:0]  id_rs,
  input  logic [5:0]  id_rt,
  input  logic [3:0]  ex_opcode,
  input  logic [5:0]  ex_rd,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic w_hazard;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_flush_evt;
  logic w_unused_opcode;

  // The decoded opcode is intentionally not qualified: both fields are always compared.
  assign w_unused_opcode = ^id_opcode;

  assign w_hazard = (ex_opcode == LOAD_OP) && ((ex_rd == id_rs) || (ex_rd == id_rt));

  always_comb begin
    w_state_nxt   = ST_RUN;
    w_cnt_nxt     = r_cnt;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_flush_evt   = 1'b0;
    if (branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_flush_evt   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = FLUSH_RELOAD;
      end else begin
        w_cnt_nxt   = 4'd0;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            if (STALL_CYCLES > 1) begin
              w_state_nxt = ST_STALL;
              w_cnt_nxt   = STALL_RELOAD;
            end
          end
        end
        ST_STALL: begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          w_cnt_nxt     = r_cnt - 4'd1;
          // A zero count can only come from corruption; fall back to RUN.
          w_state_nxt   = (r_cnt > 4'd1) ? ST_STALL : ST_RUN;
          if (r_cnt == 4'd0) w_cnt_nxt = 4'd0;
        end
        ST_FLUSH: begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          w_cnt_nxt     = r_cnt - 4'd1;
          w_state_nxt   = (r_cnt > 4'd1) ? ST_FLUSH : ST_RUN;
          if (r_cnt == 4'd0) w_cnt_nxt = 4'd0;
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!w_pc_write && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_evt && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  // Reset forces a safe frozen/squashing front end without waiting for a clock.
  assign pc_write    = reset ? 1'b0 : w_pc_write;
  assign ifid_write  = reset ? 1'b0 : w_ifid_write;
  assign ifid_flush  = reset ? 1'b1 : w_ifid_flush;
  assign idex_bubble = reset ? 1'b1 : w_idex_bubble;
  assign ctrl_state  = r_state;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances with different stall
// lengths share one stimulus set; each task checks its scenario inline.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] id_opcode = 4'd0;
  logic [5:0] id_rs = 6'd0;
  logic [5:0] id_rt = 6'd0;
  logic [3:0] ex_opcode = 4'd0;
  logic [5:0] ex_rd = 6'd0;
  logic       branch_taken = 1'b0;

  logic a_pc, a_ifw, a_iff, a_bub; logic [1:0] a_st; logic [15:0] a_sc, a_fc;
  logic b_pc, b_ifw, b_iff, b_bub; logic [1:0] b_st; logic [15:0] b_sc, b_fc;
  logic c_pc, c_ifw, c_iff, c_bub; logic [1:0] c_st; logic [15:0] c_sc, c_fc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.LOAD_OP(4'b1110), .STALL_CYCLES(1), .FLUSH_CYCLES(2)) u_a (
    .clock(clock), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_iff), .idex_bubble(a_bub),
    .ctrl_state(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc));

  pipe_hazard_ctrl #(.LOAD_OP(4'b1110), .STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_b (
    .clock(clock), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_iff), .idex_bubble(b_bub),
    .ctrl_state(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc));

  pipe_hazard_ctrl #(.LOAD_OP(4'b1110), .STALL_CYCLES(4), .FLUSH_CYCLES(2)) u_c (
    .clock(clock), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_write(c_pc), .ifid_write(c_ifw), .ifid_flush(c_iff), .idex_bubble(c_bub),
    .ctrl_state(c_st), .stall_cnt(c_sc), .flush_cnt(c_fc));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    id_opcode = 4'd0; id_rs = 6'd0; id_rt = 6'd0;
    ex_opcode = 4'd0; ex_rd = 6'd0; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #3;
    n_vec++;
    if ({a_pc, a_ifw, a_iff, a_bub, a_st} !== 6'b0011_00) begin
      n_err++; $display("FAIL reset_hold ctl=%b st=%b want 0011 00", {a_pc, a_ifw, a_iff, a_bub}, a_st);
    end
    tick();
    reset = 1'b0;
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    #1;
    n_vec++;
    if (a_st !== 2'b10) begin
      n_err++; $display("FAIL reset_pre_flush st=%b want 10", a_st);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({a_pc, a_ifw, a_iff, a_bub, a_st} !== 6'b0011_00) begin
      n_err++; $display("FAIL reset_mid_flush ctl=%b st=%b want 0011 00", {a_pc, a_ifw, a_iff, a_bub}, a_st);
    end
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if ({a_pc, a_ifw, a_iff, a_bub, a_st} !== 6'b1100_00 || a_sc !== 16'd0 || a_fc !== 16'd0) begin
      n_err++; $display("FAIL reset_release ctl=%b st=%b sc=%0d fc=%0d want 1100 00 0 0",
                        {a_pc, a_ifw, a_iff, a_bub}, a_st, a_sc, a_fc);
    end
  endtask

  task automatic test_load_stall1();
    do_reset();
    ex_opcode = 4'b1110; ex_rd = 6'd5; id_rs = 6'd5; id_rt = 6'd0;
    #1;
    n_vec++;
    if ({a_pc, a_ifw, a_iff, a_bub, a_st} !== 6'b0001_00) begin
      n_err++; $display("FAIL stall1_freeze ctl=%b st=%b want 0001 00", {a_pc, a_ifw, a_iff, a_bub}, a_st);
    end
    tick();
    ex_opcode = 4'd0;
    #1;
    n_vec++;
    if ({a_pc, a_ifw, a_iff, a_bub, a_st} !== 6'b1100_00 || a_sc !== 16'd1) begin
      n_err++; $display("FAIL stall1_resume ctl=%b st=%b sc=%0d want 1100 00 1",
                        {a_pc, a_ifw, a_iff, a_bub}, a_st, a_sc);
    end
  endtask

  task automatic test_load_stall3();
    logic [1:0] exp_st [3];
    exp_st[0] = 2'b00; exp_st[1] = 2'b01; exp_st[2] = 2'b01;
    do_reset();
    ex_opcode = 4'b1110; ex_rd = 6'd63; id_rt = 6'd63; id_rs = 6'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({b_pc, b_ifw, b_iff, b_bub} !== 4'b0001 || b_st !== exp_st[i]) begin
        n_err++; $display("FAIL stall3_cycle%0d ctl=%b st=%b want 0001 %b",
                          i, {b_pc, b_ifw, b_iff, b_bub}, b_st, exp_st[i]);
      end
      tick();
      ex_opcode = 4'd0;
    end
    #1;
    n_vec++;
    if ({b_pc, b_ifw, b_iff, b_bub, b_st} !== 6'b1100_00 || b_sc !== 16'd3) begin
      n_err++; $display("FAIL stall3_resume ctl=%b st=%b sc=%0d want 1100 00 3",
                        {b_pc, b_ifw, b_iff, b_bub}, b_st, b_sc);
    end
    ex_opcode = 4'b1110; ex_rd = 6'd7; id_rs = 6'd8; id_rt = 6'd9;
    #1;
    n_vec++;
    if ({b_pc, b_ifw, b_iff, b_bub} !== 4'b1100) begin
      n_err++; $display("FAIL load_nomatch ctl=%b want 1100", {b_pc, b_ifw, b_iff, b_bub});
    end
    ex_opcode = 4'b0011; ex_rd = 6'd8;
    #1;
    n_vec++;
    if ({b_pc, b_ifw, b_iff, b_bub} !== 4'b1100) begin
      n_err++; $display("FAIL nonload_match ctl=%b want 1100", {b_pc, b_ifw, b_iff, b_bub});
    end
    ex_opcode = 4'b1110; ex_rd = 6'd0; id_rs = 6'd0; id_rt = 6'd1;
    #1;
    n_vec++;
    if ({b_pc, b_ifw, b_iff, b_bub} !== 4'b0001) begin
      n_err++; $display("FAIL load_r0_match ctl=%b want 0001", {b_pc, b_ifw, b_iff, b_bub});
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1'b1;
    #1;
    n_vec++;
    if ({a_pc, a_ifw, a_iff, a_bub, a_st} !== 6'b1111_00) begin
      n_err++; $display("FAIL branch_cycle0 ctl=%b st=%b want 1111 00", {a_pc, a_ifw, a_iff, a_bub}, a_st);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    n_vec++;
    if ({a_pc, a_ifw, a_iff, a_bub, a_st} !== 6'b1111_10) begin
      n_err++; $display("FAIL branch_cycle1 ctl=%b st=%b want 1111 10", {a_pc, a_ifw, a_iff, a_bub}, a_st);
    end
    tick();
    n_vec++;
    if ({a_pc, a_ifw, a_iff, a_bub, a_st} !== 6'b1100_00 || a_fc !== 16'd1 || a_sc !== 16'd0) begin
      n_err++; $display("FAIL branch_done ctl=%b st=%b fc=%0d sc=%0d want 1100 00 1 0",
                        {a_pc, a_ifw, a_iff, a_bub}, a_st, a_fc, a_sc);
    end
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    ex_opcode = 4'b1110; ex_rd = 6'd5; id_rs = 6'd5;
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if ({c_pc, c_ifw, c_iff, c_bub, c_st} !== 6'b0001_01) begin
      n_err++; $display("FAIL bis_stall1 ctl=%b st=%b want 0001 01", {c_pc, c_ifw, c_iff, c_bub}, c_st);
    end
    tick();
    branch_taken = 1'b1;
    #1;
    n_vec++;
    if ({c_pc, c_ifw, c_iff, c_bub, c_st} !== 6'b1111_01) begin
      n_err++; $display("FAIL bis_switch ctl=%b st=%b want 1111 01", {c_pc, c_ifw, c_iff, c_bub}, c_st);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    n_vec++;
    if ({c_pc, c_ifw, c_iff, c_bub, c_st} !== 6'b1111_10 || c_fc !== 16'd1) begin
      n_err++; $display("FAIL bis_flush ctl=%b st=%b fc=%0d want 1111 10 1",
                        {c_pc, c_ifw, c_iff, c_bub}, c_st, c_fc);
    end
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    #1;
    n_vec++;
    if ({c_pc, c_ifw, c_iff, c_bub, c_st} !== 6'b1111_10 || c_fc !== 16'd2) begin
      n_err++; $display("FAIL bis_reload ctl=%b st=%b fc=%0d want 1111 10 2",
                        {c_pc, c_ifw, c_iff, c_bub}, c_st, c_fc);
    end
    tick();
    n_vec++;
    if ({c_pc, c_ifw, c_iff, c_bub, c_st} !== 6'b1100_00 || c_sc !== 16'd2 || c_fc !== 16'd2) begin
      n_err++; $display("FAIL bis_done ctl=%b st=%b sc=%0d fc=%0d want 1100 00 2 2",
                        {c_pc, c_ifw, c_iff, c_bub}, c_st, c_sc, c_fc);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_opcode = 4'b1110; ex_rd = 6'd12; id_rs = 6'd12;
    repeat (65534) tick();
    n_vec++;
    if (a_sc !== 16'hFFFE) begin
      n_err++; $display("FAIL sat_near sc=%h want fffe", a_sc);
    end
    repeat (4466) tick();
    n_vec++;
    if (a_sc !== 16'hFFFF || a_pc !== 1'b0) begin
      n_err++; $display("FAIL sat_hold sc=%h pc=%b want ffff 0", a_sc, a_pc);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_stall1();
    test_load_stall3();
    test_branch();
    test_branch_in_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
